// File: rtl/xor21_parity_sched.sv
// Round-robin scheduler that streams requester words through one shared
// 21-input XOR cell, one slice per cycle, and returns the even-parity bit.
//
// state | meaning
// IDLE  | waiting for a request; XA parked at zero
// RUN   | driving slice SC of the captured word onto XA, folding XZ into ACC
// DONE  | parity complete; result registered onto PAR/RID/VALID next edge
module xor21_parity_sched #(
  parameter int NREQ = 4,
  parameter int SLICES = 4,
  localparam int W = 21 * SLICES,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] DIN,
  output logic [NREQ-1:0]   GNT,
  output logic [20:0]       XA,
  input  logic              XZ,
  output logic              VALID,
  output logic              PAR,
  output logic [IDW-1:0]    RID,
  output logic              BUSY
);

  localparam int SCW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id, win, idx;
  logic           found;
  logic [W-1:0]   sh;
  logic [SCW-1:0] sc;
  logic           acc;
  logic           last_slice;

  logic [W-1:0]   din_a   [NREQ];
  logic [20:0]    slice_a [SLICES];

  for (genvar g = 0; g < NREQ; g++) begin : g_din
    assign din_a[g] = DIN[g*W +: W];
  end

  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    assign slice_a[g] = sh[g*21 +: 21];
  end

  assign last_slice = (sc == SCW'(SLICES - 1));

  // First set request at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    XA        = '0;
    case (state)
      IDLE: if (found) state_nxt = RUN;
      RUN: begin
        XA = slice_a[sc];
        if (last_slice) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state <= IDLE;
      ptr   <= '0;
      acc   <= 1'b0;
      sc    <= '0;
      sh    <= '0;
      id    <= '0;
      GNT   <= '0;
      VALID <= 1'b0;
      PAR   <= 1'b0;
      RID   <= '0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      GNT   <= '0;
      VALID <= (state == DONE);
      BUSY  <= (state_nxt != IDLE);
      if (state == DONE) begin
        PAR <= acc;
        RID <= id;
      end
      case (state)
        IDLE: begin
          if (found) begin
            sh       <= din_a[win];
            id       <= win;
            acc      <= 1'b0;
            sc       <= '0;
            ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            GNT[win] <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc ^ XZ;
          if (!last_slice) sc <= sc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor21_parity_sched.sv
// Directed bench for xor21_parity_sched: a 4x4-slice instance and a 2x1-slice
// instance, each driven by a behavioural XOR cell on XA/XZ.
module tb_xor21_parity_sched;

  logic         ck;
  logic         rstn;
  logic [3:0]   req, gnt;
  logic [335:0] din;
  logic [20:0]  xa;
  logic         xz, valid, par, busy;
  logic [1:0]   rid;

  logic [1:0]   req_b, gnt_b;
  logic [41:0]  din_b;
  logic [20:0]  xa_b;
  logic         xz_b, valid_b, par_b, busy_b;
  logic [0:0]   rid_b;

  int vecs;
  int errs;

  assign xz   = ^xa;
  assign xz_b = ^xa_b;

  xor21_parity_sched #(.NREQ(4), .SLICES(4)) dut (
    .CK(ck), .RSTN(rstn), .REQ(req), .DIN(din), .GNT(gnt), .XA(xa), .XZ(xz),
    .VALID(valid), .PAR(par), .RID(rid), .BUSY(busy)
  );

  xor21_parity_sched #(.NREQ(2), .SLICES(1)) dut_b (
    .CK(ck), .RSTN(rstn), .REQ(req_b), .DIN(din_b), .GNT(gnt_b), .XA(xa_b), .XZ(xz_b),
    .VALID(valid_b), .PAR(par_b), .RID(rid_b), .BUSY(busy_b)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Counts falling edges until VALID is seen; cyc = -1 if the budget runs out.
  task automatic wait_valid(input int max, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= max; i++) begin
      if (!seen) begin
        @(negedge ck);
        if (valid === 1'b1) begin
          seen = 1'b1;
          cyc  = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [83:0] w;
    int cyc;
    rstn  = 1'b0;
    req   = 4'($urandom());
    for (int i = 0; i < 10; i++) din[i*32 +: 32] = $urandom();
    din[335:320] = 16'($urandom());
    req_b = 2'($urandom());
    din_b = 42'({$urandom(), $urandom()});
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      vecs++;
      if ({gnt, valid, par, rid, xa, busy} !== 30'b0) begin
        errs++;
        $display("FAIL reset_outputs cycle %0d: got gnt=%b valid=%b par=%b rid=%0d xa=%h busy=%b, expected all zero",
                 i, gnt, valid, par, rid, xa, busy);
      end
      vecs++;
      if ({gnt_b, valid_b, par_b, rid_b, xa_b, busy_b} !== 27'b0) begin
        errs++;
        $display("FAIL reset_outputs_b cycle %0d: got gnt=%b valid=%b par=%b rid=%0d xa=%h busy=%b, expected all zero",
                 i, gnt_b, valid_b, par_b, rid_b, xa_b, busy_b);
      end
    end
    w = 84'h5;
    din = '0;
    din[1*84 +: 84] = w;
    din[3*84 +: 84] = 84'hFFF;
    req   = 4'b1010;
    req_b = 2'b00;
    rstn  = 1'b1;
    @(negedge ck);
    vecs++;
    if (gnt !== 4'b0010) begin
      errs++;
      $display("FAIL reset_first_grant: got %b expected 0010", gnt);
    end
    req = 4'b0000;
    wait_valid(10, cyc);
    vecs++;
    if (cyc !== 5 || rid !== 2'd1 || par !== 1'b0) begin
      errs++;
      $display("FAIL reset_first_result: got cyc=%0d rid=%0d par=%b expected cyc=5 rid=1 par=0", cyc, rid, par);
    end
  endtask

  task automatic test_single();
    logic [20:0] sl [4];
    sl[0] = 21'h1FFFFF;
    sl[1] = 21'h0000FF;
    sl[2] = 21'h00000F;
    sl[3] = 21'h100007;
    din = '0;
    din[2*84 +: 84] = {sl[3], sl[2], sl[1], sl[0]};
    req = 4'b0100;
    @(negedge ck);
    vecs++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      errs++;
      $display("FAIL single_grant: got gnt=%b busy=%b expected gnt=0100 busy=1", gnt, busy);
    end
    req = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        @(negedge ck);
        vecs++;
        if (gnt !== 4'b0000) begin
          errs++;
          $display("FAIL single_gnt_pulse slice %0d: got %b expected 0000", s, gnt);
        end
      end
      vecs++;
      if (xa !== sl[s]) begin
        errs++;
        $display("FAIL single_xa slice %0d: got %h expected %h", s, xa, sl[s]);
      end
    end
    @(negedge ck);
    vecs++;
    if (xa !== 21'h0 || valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL single_done: got xa=%h valid=%b busy=%b expected xa=0 valid=0 busy=1", xa, valid, busy);
    end
    @(negedge ck);
    vecs++;
    if (valid !== 1'b1 || par !== 1'b1 || rid !== 2'd2 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_result: got valid=%b par=%b rid=%0d busy=%b expected valid=1 par=1 rid=2 busy=0",
               valid, par, rid, busy);
    end
    @(negedge ck);
    vecs++;
    if (valid !== 1'b0 || par !== 1'b1 || rid !== 2'd2) begin
      errs++;
      $display("FAIL single_hold: got valid=%b par=%b rid=%0d expected valid=0 par=1 rid=2", valid, par, rid);
    end
  endtask

  task automatic test_fairness();
    logic [83:0] fw [4];
    logic [3:0]  fpar;
    int raise_at [4];
    int ngnt, nval, last_val;
    fw[0] = 84'h1;
    fw[1] = 84'h3;
    fw[2] = 84'hF0F;
    fw[3] = 84'h8_0000_0000_0000_0000_0003;
    fpar  = 4'b1001;
    rstn = 1'b0;
    @(negedge ck);
    rstn = 1'b1;
    din = {fw[3], fw[2], fw[1], fw[0]};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) raise_at[i] = -1;
    ngnt = 0;
    nval = 0;
    last_val = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge ck);
      for (int i = 0; i < 4; i++) begin
        if (raise_at[i] == cyc) begin
          req[i] = 1'b1;
          raise_at[i] = -1;
        end
      end
      if (gnt !== 4'b0000) begin
        vecs++;
        if (gnt !== 4'(1 << (ngnt % 4))) begin
          errs++;
          $display("FAIL fair_order grant %0d: got %b expected %b", ngnt, gnt, 4'(1 << (ngnt % 4)));
        end
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            req[i] = 1'b0;
            raise_at[i] = cyc + 2;
          end
        end
        ngnt++;
      end
      if (valid === 1'b1) begin
        vecs++;
        if (rid !== 2'(nval % 4) || par !== fpar[nval % 4]) begin
          errs++;
          $display("FAIL fair_result %0d: got rid=%0d par=%b expected rid=%0d par=%b",
                   nval, rid, par, nval % 4, fpar[nval % 4]);
        end
        if (nval > 0) begin
          vecs++;
          if (cyc - last_val != 6) begin
            errs++;
            $display("FAIL fair_spacing %0d: got %0d cycles expected 6", nval, cyc - last_val);
          end
        end
        last_val = cyc;
        nval++;
      end
    end
    vecs++;
    if (ngnt < 6 || nval < 6) begin
      errs++;
      $display("FAIL fair_count: got grants=%0d results=%0d expected at least 6 each", ngnt, nval);
    end
    req = 4'b0000;
    repeat (10) @(negedge ck);
  endtask

  task automatic test_parity_corners();
    logic [83:0] cw [5];
    logic [4:0]  cpar;
    logic [83:0] wv;
    cw[0] = 84'h0;
    cw[1] = {84{1'b1}};
    cw[2] = 84'h1 << 20;
    cw[3] = 84'h1 << 21;
    cw[4] = 84'h1 << 83;
    cpar  = 5'b11100;
    for (int v = 0; v < 5; v++) begin
      wv  = cw[v];
      din = '0;
      din[83:0] = wv;
      req = 4'b0001;
      @(negedge ck);
      vecs++;
      if (gnt !== 4'b0001) begin
        errs++;
        $display("FAIL corner_grant %0d: got %b expected 0001", v, gnt);
      end
      req = 4'b0000;
      for (int s = 0; s < 4; s++) begin
        if (s > 0) @(negedge ck);
        vecs++;
        if (xa !== wv[21*s +: 21]) begin
          errs++;
          $display("FAIL corner_xa %0d slice %0d: got %h expected %h", v, s, xa, wv[21*s +: 21]);
        end
      end
      @(negedge ck);
      @(negedge ck);
      vecs++;
      if (valid !== 1'b1 || par !== cpar[v]) begin
        errs++;
        $display("FAIL corner_par %0d: got valid=%b par=%b expected valid=1 par=%b", v, valid, par, cpar[v]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nv, cyc;
    din = '0;
    din[83:0] = 84'h7;
    req = 4'b0001;
    @(negedge ck);
    req = 4'b0000;
    @(negedge ck);
    rstn = 1'b0;
    @(negedge ck);
    rstn = 1'b1;
    vecs++;
    if (busy !== 1'b0 || valid !== 1'b0 || gnt !== 4'b0000 || xa !== 21'h0) begin
      errs++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b gnt=%b xa=%h expected all zero", busy, valid, gnt, xa);
    end
    nv = 0;
    repeat (8) begin
      @(negedge ck);
      if (valid !== 1'b0) nv++;
    end
    vecs++;
    if (nv != 0) begin
      errs++;
      $display("FAIL midreset_novalid: got %0d valid cycles expected 0", nv);
    end
    req = 4'b1001;
    @(negedge ck);
    vecs++;
    if (gnt !== 4'b0001) begin
      errs++;
      $display("FAIL midreset_ptr: got gnt=%b expected 0001", gnt);
    end
    req = 4'b0000;
    wait_valid(10, cyc);
    vecs++;
    if (cyc !== 5 || rid !== 2'd0 || par !== 1'b1) begin
      errs++;
      $display("FAIL midreset_result: got cyc=%0d rid=%0d par=%b expected cyc=5 rid=0 par=1", cyc, rid, par);
    end
  endtask

  task automatic test_back_to_back();
    int ngnt, nval, last_val;
    din_b = {21'h3, 21'h1};
    req_b = 2'b11;
    ngnt = 0;
    nval = 0;
    last_val = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge ck);
      if (gnt_b !== 2'b00) begin
        vecs++;
        if (gnt_b !== ((ngnt == 0) ? 2'b01 : 2'b10)) begin
          errs++;
          $display("FAIL b2b_grant %0d: got %b expected %b", ngnt, gnt_b, (ngnt == 0) ? 2'b01 : 2'b10);
        end
        req_b = req_b & ~gnt_b;
        ngnt++;
      end
      if (valid_b === 1'b1) begin
        vecs++;
        if (par_b !== ((nval == 0) ? 1'b1 : 1'b0) || rid_b !== ((nval == 0) ? 1'b0 : 1'b1)) begin
          errs++;
          $display("FAIL b2b_result %0d: got par=%b rid=%0d expected par=%b rid=%0d",
                   nval, par_b, rid_b, (nval == 0) ? 1'b1 : 1'b0, (nval == 0) ? 0 : 1);
        end
        if (nval > 0) begin
          vecs++;
          if (cyc - last_val != 3) begin
            errs++;
            $display("FAIL b2b_spacing: got %0d cycles expected 3", cyc - last_val);
          end
        end
        last_val = cyc;
        nval++;
      end
    end
    vecs++;
    if (ngnt != 2 || nval != 2) begin
      errs++;
      $display("FAIL b2b_count: got grants=%0d results=%0d expected 2 and 2", ngnt, nval);
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    rstn  = 1'b0;
    req   = '0;
    din   = '0;
    req_b = '0;
    din_b = '0;
    test_reset();
    test_single();
    test_fairness();
    test_parity_corners();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
